// File: rtl/iob_fifo_t2p_ctrl.sv
// Single-clock FIFO controller driving an external true two-port RAM.
// Tracks pointers, occupancy, read-valid and sticky error flags.
module iob_fifo_t2p_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_full,
  input  logic              r_en,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              r_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  output logic              ext_mem_w_en,
  output logic [ADDR_W-1:0] ext_mem_w_addr,
  output logic [DATA_W-1:0] ext_mem_w_data,
  output logic              ext_mem_r_en,
  output logic [ADDR_W-1:0] ext_mem_r_addr,
  input  logic [DATA_W-1:0] ext_mem_r_data
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LVL_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              r_valid_q, r_valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_ok;
  logic              pop_ok;

  assign w_full  = (level_q == DEPTH);
  assign r_empty = (level_q == '0);

  // clr masks both accepts so the RAM sees no access in the clear cycle
  assign push_ok = w_en & ~w_full & ~clr;
  assign pop_ok  = r_en & ~r_empty & ~clr;

  assign ext_mem_w_en   = push_ok;
  assign ext_mem_w_addr = wptr_q;
  assign ext_mem_w_data = w_data;
  assign ext_mem_r_en   = pop_ok;
  assign ext_mem_r_addr = rptr_q;

  assign r_data    = ext_mem_r_data;
  assign r_valid   = r_valid_q;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // Next-state: clear wins, otherwise pointer/level/flag updates
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;
    r_valid_d = pop_ok;
    ovf_d     = ovf_q | (w_en & w_full);
    unf_d     = unf_q | (r_en & r_empty);
    if (push_ok) wptr_d = wptr_q + PTR_ONE;
    if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    if (clr) begin
      wptr_d    = '0;
      rptr_d    = '0;
      level_d   = '0;
      r_valid_d = 1'b0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
    end
  end

  // State registers with async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      r_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      r_valid_q <= r_valid_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

endmodule

// File: tb/tb_iob_fifo_t2p_ctrl.sv
// Bench for iob_fifo_t2p_ctrl with a behavioural two-port RAM.
// Reference model plus scoreboard of popped words.
module tb_iob_fifo_t2p_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          w_en = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          r_en = 1'b0;
  logic          w_full, r_valid, r_empty;
  logic          overflow, underflow;
  logic [DW-1:0] r_data;
  logic [AW:0]   level;
  logic          m_w_en, m_r_en;
  logic [AW-1:0] m_w_addr, m_r_addr;
  logic [DW-1:0] m_w_data, m_r_data;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;

  // reference model state
  int            mlevel;
  logic [AW-1:0] mwptr, mrptr;
  logic          movf, munf, mvalid;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] sb[$];

  typedef struct {
    logic          w;
    logic          r;
    logic          c;
    logic [DW-1:0] d;
    int            lvl;
    logic          ovf;
    logic          unf;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (m_w_en) mem[m_w_addr] <= m_w_data;
    if (m_r_en) m_r_data <= mem[m_r_addr];
  end

  iob_fifo_t2p_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .w_en(w_en),
    .w_data(w_data),
    .w_full(w_full),
    .r_en(r_en),
    .r_data(r_data),
    .r_valid(r_valid),
    .r_empty(r_empty),
    .level(level),
    .overflow(overflow),
    .underflow(underflow),
    .ext_mem_w_en(m_w_en),
    .ext_mem_w_addr(m_w_addr),
    .ext_mem_w_data(m_w_data),
    .ext_mem_r_en(m_r_en),
    .ext_mem_r_addr(m_r_addr),
    .ext_mem_r_data(m_r_data)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mlevel = 0;
    mwptr = '0;
    mrptr = '0;
    movf = 0;
    munf = 0;
    mvalid = 0;
    mq.delete();
    sb.delete();
  endtask

  // called at posedge+1: drive, check at negedge, advance model, step edge
  task automatic step(input logic w, input logic r,
                      input logic c, input logic [DW-1:0] d);
    logic full, empty, pok, rok;
    logic [DW-1:0] e;
    w_en = w;
    r_en = r;
    clr = c;
    w_data = d;
    #4;
    full = (mlevel == 16);
    empty = (mlevel == 0);
    pok = w & !full & !c;
    rok = r & !empty & !c;
    chk("level", int'(level), mlevel);
    chk("w_full", int'(w_full), int'(full));
    chk("r_empty", int'(r_empty), int'(empty));
    chk("overflow", int'(overflow), int'(movf));
    chk("underflow", int'(underflow), int'(munf));
    chk("r_valid", int'(r_valid), int'(mvalid));
    chk("mem_w_en", int'(m_w_en), int'(pok));
    chk("mem_r_en", int'(m_r_en), int'(rok));
    if (pok) begin
      chk("w_addr", int'(m_w_addr), int'(mwptr));
      chk("w_data", int'(m_w_data), int'(d));
    end
    if (rok) chk("r_addr", int'(m_r_addr), int'(mrptr));
    if (mvalid) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        chk("r_data", int'(r_data), int'(e));
      end
    end
    if (c) model_reset();
    else begin
      movf = movf | (w & full);
      munf = munf | (r & empty);
      if (pok) begin
        mq.push_back(d);
        mwptr = mwptr + 1'b1;
      end
      if (rok) begin
        sb.push_back(mq.pop_front());
        mrptr = mrptr + 1'b1;
      end
      mlevel = mlevel + int'(pok) - int'(rok);
      mvalid = rok;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{w:1, r:1, c:0, d:8'h55, lvl:15, ovf:1, unf:0};
    tbl[1] = '{w:1, r:0, c:0, d:8'h77, lvl:16, ovf:1, unf:0};
    tbl[2] = '{w:1, r:1, c:0, d:8'hAA, lvl:1,  ovf:1, unf:1};
    tbl[3] = '{w:0, r:1, c:0, d:8'h00, lvl:0,  ovf:1, unf:1};
    tbl[4] = '{w:0, r:0, c:0, d:8'h00, lvl:0,  ovf:1, unf:1};
    tbl[5] = '{w:0, r:0, c:1, d:8'h00, lvl:0,  ovf:0, unf:0};

    model_reset();
    #2;
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(r_empty), 1);
    chk("rst_full", int'(w_full), 0);
    chk("rst_valid", int'(r_valid), 0);
    chk("rst_wen", int'(m_w_en), 0);
    chk("rst_ren", int'(m_r_en), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    // fill and drain in order
    for (int i = 1; i <= 16; i++) step(1, 0, 0, DW'(i));
    chk("fill_full", int'(w_full), 1);
    chk("fill_level", int'(level), 16);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    chk("drain_empty", int'(r_empty), 1);

    // refill, then full/empty corner sequences from the table
    for (int i = 0; i < 16; i++) step(1, 0, 0, DW'(8'h20 + i));
    for (int i = 0; i < 2; i++) begin
      step(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
      chk("tbl_level", int'(level), tbl[i].lvl);
      chk("tbl_ovf", int'(overflow), int'(tbl[i].ovf));
      chk("tbl_unf", int'(underflow), int'(tbl[i].unf));
    end
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00);
    for (int i = 2; i < 6; i++) begin
      step(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
      chk("tbl_level", int'(level), tbl[i].lvl);
      chk("tbl_ovf", int'(overflow), int'(tbl[i].ovf));
      chk("tbl_unf", int'(underflow), int'(tbl[i].unf));
    end

    // wrap at constant level 3
    for (int i = 0; i < 3; i++) step(1, 0, 0, DW'(8'h30 + i));
    for (int i = 0; i < 40; i++) step(1, 1, 0, DW'($urandom_range(255)));
    chk("wrap_level", int'(level), 3);

    // clear at level 5 with a push request
    step(1, 0, 0, 8'h91);
    step(1, 0, 0, 8'h92);
    chk("pre_clr_level", int'(level), 5);
    step(1, 0, 1, 8'h93);
    chk("clr_level", int'(level), 0);
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_unf", int'(underflow), 0);

    // async reset with a read in flight
    step(1, 0, 0, 8'hC1);
    step(1, 0, 0, 8'hC2);
    step(0, 1, 0, 8'h00);
    chk("inflight_valid", int'(r_valid), 1);
    r_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(r_valid), 0);
    chk("arst_level", int'(level), 0);
    chk("arst_empty", int'(r_empty), 1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 8'h00);
    step(1, 0, 0, 8'hE5);
    step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iob_fifo_t2p_ctrl.md
Name: iob_fifo_t2p_ctrl

Overview:
- Single-clock synchronous FIFO controller. It is the initiator side of a true two-port RAM: it drives the RAM's write-port and read-port signals.
- The RAM stays external, so one controller can sit on a register-based or BRAM-based two-port instance. Both RAM clocks are tied to clk at integration.
- Adds pointer management, occupancy level, full/empty flags, read-valid tracking and sticky overflow/underflow error flags.

Parameters:
- DATA_W, 8, FIFO word width; must equal the attached RAM's DATA_W.
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W, must equal the RAM's ADDR_W.

Ports:
- clk  in  1  system clock; also drives the external RAM w_clk/r_clk.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of pointers, level and error flags.
- w_en  in  1  push request.
- w_data  in  DATA_W  push data.
- w_full  out  1  FIFO full.
- r_en  in  1  pop request.
- r_data  out  DATA_W  pop data; combinational pass-through of ext_mem_r_data.
- r_valid  out  1  r_data carries the word of the pop accepted on the previous cycle.
- r_empty  out  1  FIFO empty.
- level  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- overflow  out  1  sticky; set by a push attempted while full.
- underflow  out  1  sticky; set by a pop attempted while empty.
- ext_mem_w_en  out  1  RAM write enable.
- ext_mem_w_addr  out  ADDR_W  RAM write address.
- ext_mem_w_data  out  DATA_W  RAM write data.
- ext_mem_r_en  out  1  RAM read enable.
- ext_mem_r_addr  out  ADDR_W  RAM read address.
- ext_mem_r_data  in  DATA_W  RAM registered read data, 1-cycle latency.

Behaviour:
- Reset (rst_n low, async):
  - wptr=0, rptr=0, level=0, r_valid=0, overflow=0, underflow=0.
  - Hence r_empty=1 and w_full=0.
  - r_data is not reset; it follows RAM content.
- clr=1 at a clock edge: same state as reset. The push/pop of that cycle is ignored, and the ext_mem enables are forced to 0 that cycle. clr takes priority over all other events.
- Accept rules, combinational from registered state:
  - push_ok = w_en & ~w_full.
  - pop_ok = r_en & ~r_empty.
  - No lookahead: push when full is rejected even if a pop occurs in the same cycle; pop when empty is rejected even if a push occurs in the same cycle.
- RAM drive, combinational:
  - ext_mem_w_en=push_ok, ext_mem_w_addr=wptr, ext_mem_w_data=w_data.
  - ext_mem_r_en=pop_ok, ext_mem_r_addr=rptr.
- Pointers: ADDR_W bits, +1 on each accepted op, natural wrap from 2**ADDR_W-1 to 0.
- Level update:
  - +1 on push_ok only; -1 on pop_ok only; unchanged when both or neither.
  - w_full = (level == 2**ADDR_W); r_empty = (level == 0). Both are decoded from registered level, no combinational path from w_en/r_en.
- Read timing:
  - pop accepted at edge N → r_valid=1 during cycle N+1, with r_data = word at the old rptr.
  - r_valid returns to 0 the cycle after a non-pop cycle.
  - r_data holds its last value while ext_mem_r_en=0, because the RAM holds it.
- Write-to-read latency: a push at edge N makes r_empty=0 in cycle N+1. A pop at edge N+1 gives the data in cycle N+2, 2 cycles minimum. Read and write addresses never collide on an accepted pair, since a pop only reads written entries and no push is accepted when full.
- Error flags: overflow is set on w_en & w_full; underflow is set on r_en & r_empty. Both hold until clr or reset.
- Reset mid-operation: any in-flight read is discarded (r_valid=0). RAM content is retained but unreachable.

Test Plan:
- Reset, then idle → r_empty=1, w_full=0, level=0, r_valid=0, ext_mem_w_en=ext_mem_r_en=0.
- ADDR_W=4: push 0x01..0x10 over 16 cycles, then pop 16 → w_full=1 and level=16 after the 16th push; pops return 0x01..0x10 in order, each with r_valid one cycle after r_en; r_empty=1 at the end.
- Full FIFO, assert w_en and r_en together → write rejected (ext_mem_w_en=0), pop accepted, level 16→15, overflow=1; a further push is accepted.
- Empty FIFO, w_en=r_en=1 with w_data=0xAA → push accepted, pop rejected, level=1, underflow=1; next cycle pop → r_data=0xAA with r_valid=1.
- Wrap: 40 cycles of simultaneous push/pop at level 3 → level stays 3, pointers wrap past 15, data order preserved.
- clr at level 5 with w_en=1, then rst_n pulse low mid-pop → level=0, flags cleared, ext_mem_w_en=0 in the clr cycle; r_valid drops immediately on rst_n low.
